// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;
  localparam int BYTE_W      = 8;
  localparam int DEFAULT_GAP = 15000;

  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);
  logic [IW-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of a single UART byte transmitter,
// with a fixed idle gap after every byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int GAP_CYCLES = DEFAULT_GAP,
  localparam int CNT_W      = $clog2(GAP_CYCLES + 1),
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       word,
  output logic                    tx_en,
  input  logic                    tx_done,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);
  state_e            r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_word;
  logic              r_tx_en;
  logic              r_lock;
  logic [N_REQ-1:0]  r_grant;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic [N_REQ-1:0]  w_pick_oh;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_acc;
  logic [N_REQ-1:0]  w_acc_oh;
  logic [IW-1:0]     w_acc_idx;
  logic              w_release;
  logic              w_gap_end;
  logic              w_own_valid;
  logic [BYTE_W-1:0] w_bytes [N_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  assign w_gap_end   = (r_cnt == CNT_W'(GAP_CYCLES - 1));
  assign w_own_valid = |(req_valid & r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_acc_oh    = '0;
    w_acc_idx   = r_owner;
    w_release   = 1'b0;
    case (r_state)
      IDLE: if (w_pick_any) begin
        w_acc       = 1'b1;
        w_acc_oh    = w_pick_oh;
        w_acc_idx   = w_pick_idx;
        w_state_nxt = SEND;
      end
      SEND: if (tx_done) w_state_nxt = GAP;
      GAP: if (w_gap_end) begin
        if (!r_lock) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_own_valid) begin
          w_acc       = 1'b1;
          w_acc_oh    = r_grant;
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: if (w_own_valid) begin
        w_acc       = 1'b1;
        w_acc_oh    = r_grant;
        w_state_nxt = SEND;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_word   <= '0;
      r_tx_en  <= 1'b0;
      r_lock   <= 1'b0;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_word  <= w_bytes[w_acc_idx];
        r_grant <= w_acc_oh;
        r_owner <= w_acc_idx;
        r_lock  <= ~req_last[w_acc_idx];
        r_tx_en <= 1'b1;
      end
      if (r_state == SEND && tx_done) begin
        r_tx_en <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == GAP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Pointer always moves past the finishing owner, whoever else was waiting.
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
    end
  end

  assign req_ready = w_acc_oh;
  assign word      = r_word;
  assign tx_en     = r_tx_en;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued message sources, a delayed-done transmitter,
// and a transaction-level round-robin model predicting byte order.
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N     = 4;
  localparam int GAP_N = 4;

  typedef struct {int idx; logic [7:0] data; logic last;} acc_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic [7:0]     word;
  logic           tx_en, busy, tx_done;
  logic           txm_done = 1'b0, spur_done = 1'b0;

  int n_assert = 0, n_fail = 0;

  logic [8:0] q  [N][$];
  logic [8:0] mq [N][$];
  acc_t       log_q[$], exp_q[$];
  int         gaps[$];
  logic [N-1:0] fire = '0;
  logic       pend = 1'b0, prev_txen = 1'b0, fall_vld = 1'b0;
  acc_t       pend_a;
  int         cyc = 0, fall_cyc = 0, txm_cnt = 0;

  assign tx_done = txm_done | spur_done;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP_N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .word(word), .tx_en(tx_en),
    .tx_done(tx_done), .grant(grant), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter stand-in: done pulse 10 clk after tx_en rises.
  always @(posedge clk) begin
    #1;
    if (rst || !tx_en) begin txm_cnt = 0; txm_done = 1'b0; end
    else begin txm_cnt++; txm_done = (txm_cnt == 10); end
  end

  // Sources: present queue head, pop after a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (q[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_data[8*i+:8] = q[i][0][7:0];
        req_last[i]      = q[i][0][8];
      end else begin
        req_valid[i]     = 1'b0;
        req_data[8*i+:8] = 8'($urandom);
        req_last[i]      = 1'($urandom);
      end
    end
  end

  // Monitor: handshake log, accept-to-tx_en latency, tx_en low-gap lengths.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; fall_vld = 1'b0; fire = '0;
    end else begin
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      check("ready_while_txen", 32'((|req_ready) && tx_en), 0);
      if (pend) begin
        check("lat_txen", 32'(tx_en), 1);
        check("lat_word", 32'(word), 32'(pend_a.data));
        check("lat_grant", 32'(grant), 32'(1) << pend_a.idx);
      end
      pend = 1'b0;
      fire = req_valid & req_ready;
      for (int i = 0; i < N; i++)
        if (fire[i]) begin
          pend   = 1'b1;
          pend_a = '{i, req_data[8*i+:8], req_last[i]};
          log_q.push_back(pend_a);
        end
      if (prev_txen && !tx_en) begin fall_cyc = cyc; fall_vld = 1'b1; end
      if (!prev_txen && tx_en && fall_vld) begin
        gaps.push_back(cyc - fall_cyc);
        check("gap_min", 32'((cyc - fall_cyc) >= GAP_N), 1);
      end
    end
    prev_txen = tx_en;
    cyc++;
  end

  task automatic push(input int r, input logic [8:0] b);
    q[r].push_back(b);
    mq[r].push_back(b);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin q[i].delete(); mq[i].delete(); end
    log_q.delete(); gaps.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Whole messages, owner chosen as first non-empty source from the pointer,
  // pointer moves past each finishing owner. Pointer starts at 0 after reset.
  task automatic build_exp();
    int p = 0;
    logic [8:0] e;
    exp_q.delete();
    while (1) begin
      int w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && mq[(p + k) % N].size() > 0) w = (p + k) % N;
      if (w < 0) break;
      do begin
        e = mq[w].pop_front();
        exp_q.push_back('{w, e[7:0], e[8]});
      end while (!e[8] && mq[w].size() > 0);
      p = (w + 1) % N;
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      check({tag, "_idx"}, 32'(log_q[k].idx), 32'(exp_q[k].idx));
      check({tag, "_data"}, 32'(log_q[k].data), 32'(exp_q[k].data));
      check({tag, "_last"}, 32'(log_q[k].last), 32'(exp_q[k].last));
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(busy === 1'b0 && tx_en === 1'b0 && all_empty()) && k < 3000) begin
      @(negedge clk); k++;
    end
    check({tag, "_idle_timeout"}, 32'(k < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 500) begin @(negedge clk); k++; end
    check({tag, "_log_timeout"}, 32'(k < 500), 1);
  endtask

  task automatic wait_txen(input logic v, input string tag);
    int k = 0;
    while (tx_en !== v && k < 100) begin @(negedge clk); k++; end
    check({tag, "_txen_timeout"}, 32'(k < 100), 1);
  endtask

  initial begin
    int k;
    logic [N-1:0] g_or, g_and, r_or;

    // Reset state
    reset_dut();
    check("rst_word", 32'(word), 0);
    check("rst_txen", 32'(tx_en), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ptr", 32'(dut.r_rr_ptr), 0);
    check("rst_cnt", 32'(dut.r_cnt), 0);

    // 1: single-byte message from source 1
    push(1, 9'h150);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("t1_word", 32'(word), 32'h50);
    check("t1_txen", 32'(tx_en), 1);
    check("t1_grant", 32'(grant), 32'h2);
    check("t1_busy", 32'(busy), 1);
    wait_txen(1'b0, "t1");
    k = 0;
    while (busy === 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("t1_gap_to_idle", 32'(k), GAP_N);
    check("t1_grant_free", 32'(grant), 0);
    check("t1_ptr", 32'(dut.r_rr_ptr), 2);

    // 2: message lock, source 2 waiting throughout
    reset_dut();
    push(0, 9'h068); push(0, 9'h169); push(2, 9'h12A);
    build_exp();
    wait_log(1, "t2");
    wait_txen(1'b0, "t2");
    g_or = '0; g_and = '1; r_or = '0; k = 0;
    while (tx_en === 1'b0 && k < 100) begin
      g_or |= grant; g_and &= grant; r_or |= req_ready;
      @(negedge clk); k++;
    end
    check("t2_grant_or", 32'(g_or), 32'h1);
    check("t2_grant_and", 32'(g_and), 32'h1);
    check("t2_ready_in_gap", 32'(r_or), 32'h1);
    wait_idle("t2");
    compare_log("t2");
    check("t2_intra_gap", 32'(gaps.size() > 0 ? gaps[0] : -1), GAP_N);

    // 3a: all four sources, two single-byte messages each
    reset_dut();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < N; r++) push(r, {1'b1, 8'($urandom)});
    build_exp();
    wait_idle("t3a");
    compare_log("t3a");

    // 3b: random message counts and lengths
    for (int round = 0; round < 3; round++) begin
      reset_dut();
      for (int r = 0; r < N; r++) begin
        int nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          int len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push(r, {1'(b == len - 1), 8'($urandom)});
        end
      end
      build_exp();
      wait_idle("t3b");
      compare_log("t3b");
    end

    // 4: HOLD with another source waiting
    reset_dut();
    push(3, 9'h0A5);
    wait_log(1, "t4");
    push(0, 9'h1C3);
    r_or = '0;
    repeat (30) begin @(negedge clk); r_or |= req_ready; end
    check("t4_no_ready", 32'(r_or), 0);
    check("t4_state", 32'(dut.r_state), 32'(HOLD));
    check("t4_grant", 32'(grant), 32'h8);
    check("t4_txen", 32'(tx_en), 0);
    check("t4_log", 32'(log_q.size()), 1);
    push(3, 9'h15A);
    @(negedge clk);
    check("t4_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    check("t4_txen_rise", 32'(tx_en), 1);
    check("t4_word", 32'(word), 32'h5A);
    wait_idle("t4");
    exp_q.delete();
    exp_q.push_back('{3, 8'hA5, 1'b0});
    exp_q.push_back('{3, 8'h5A, 1'b1});
    exp_q.push_back('{0, 8'hC3, 1'b1});
    compare_log("t4");

    // 5: spurious done in IDLE, then reset in the middle of SEND
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    check("t5_spur_busy", 32'(busy), 0);
    check("t5_spur_txen", 32'(tx_en), 0);
    check("t5_spur_state", 32'(dut.r_state), 32'(IDLE));
    push(2, 9'h011); push(2, 9'h122);
    wait_txen(1'b1, "t5");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    clear_all();
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_txen", 32'(tx_en), 0);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_word", 32'(word), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ptr", 32'(dut.r_rr_ptr), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    push(0, 9'h1E0); push(3, 9'h1E3);
    build_exp();
    @(negedge clk);
    check("t5_pick_from0", 32'(req_ready), 32'h1);
    wait_idle("t5");
    compare_log("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
